// File: rtl/spi_rx_word_packer_if.sv
// ---------------------------------------------------------------------------
// spi_rx_word_packer_if
//
// Bundles the two data paths of the receive word packer: the byte-wide
// receive FIFO it drains and the 32-bit word it offers to the AXI read-data
// register bank.
//
// Signals
//   fifo_data   8   FIFO head byte, valid while fifo_empty is low
//   fifo_empty  1   FIFO empty flag
//   fifo_count  9   FIFO occupancy
//   fifo_rd_en  1   FIFO pop, driven by the packer
//   word_data   32  packed word, driven by the packer
//   word_bytes  3   number of valid bytes in word_data (1..4)
//   word_valid  1   a word is being offered to the bus
//   word_ack    1   the bus has consumed the offered word
//
// Modports
//   master  the packer itself (pops the FIFO, offers words)
//   slave   the environment (FIFO plus register bank)
// ---------------------------------------------------------------------------
interface spi_rx_word_packer_if;

    logic [7:0]  fifo_data;
    logic        fifo_empty;
    logic [8:0]  fifo_count;
    logic        fifo_rd_en;
    logic [31:0] word_data;
    logic [2:0]  word_bytes;
    logic        word_valid;
    logic        word_ack;

    modport master (
        input  fifo_data,
        input  fifo_empty,
        input  fifo_count,
        input  word_ack,
        output fifo_rd_en,
        output word_data,
        output word_bytes,
        output word_valid
    );

    modport slave (
        output fifo_data,
        output fifo_empty,
        output fifo_count,
        output word_ack,
        input  fifo_rd_en,
        input  word_data,
        input  word_bytes,
        input  word_valid
    );

endinterface

// File: rtl/spi_rx_word_packer.sv
// ---------------------------------------------------------------------------
// spi_rx_word_packer
//
// Drains the 8-bit Quad-SPI receive FIFO and packs its bytes into 32-bit
// words for the AXI read-data register. The block owns the FIFO read-enable,
// emits partial words when flushed, and raises a level-sensitive
// FIFO-threshold interrupt.
//
// Parameters
//   LSB_FIRST       1: first byte lands in word_data[7:0]; 0: in [31:24]
//   TIMEOUT_CYCLES  idle cycles before an automatic partial flush
//                   (exists only when SPI_RX_TIMEOUT_EN is defined)
//
// Ports
//   clk           system clock, rising edge
//   reset         asynchronous, active-high reset
//   enable        drain enable
//   flush         single-cycle pulse: emit the held partial word
//   thresh        interrupt threshold, 0 disables the interrupt
//   bus           spi_rx_word_packer_if.master (FIFO side + word side)
//   irq_thresh    registered level: fifo_count >= thresh (thresh != 0)
//   busy          FSM not idle, or partial bytes are held
//   timeout_flag  sticky: an idle-timeout flush has occurred
//
// Build option
//   SPI_RX_TIMEOUT_EN  when defined, a partial word that sits with an empty
//                      FIFO for TIMEOUT_CYCLES cycles is flushed on its own
//                      and timeout_flag is set. When undefined no counter
//                      exists and timeout_flag is tied low.
// ---------------------------------------------------------------------------
module spi_rx_word_packer #(
    parameter bit LSB_FIRST = 1'b1
`ifdef SPI_RX_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYCLES = 256
`endif
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        enable,
    input  logic                        flush,
    input  logic [8:0]                  thresh,
    spi_rx_word_packer_if.master        bus,
    output logic                        irq_thresh,
    output logic                        busy,
    output logic                        timeout_flag
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [2:0]  byte_cnt;
    logic [31:0] word_reg;
    logic        flush_pending;
    logic        pop;
    logic        enter_hold;
    logic        flush_req;
    logic        pending_clear;
    logic [1:0]  lane_sel;
    logic        timeout_fire;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and pop decision. A word is closed either by the fourth pop
    // (same cycle, so the word is offered the cycle after the last pop) or by
    // a pending flush in a cycle where no pop happens. "No pop" covers both an
    // empty FIFO and a dropped enable, so held bytes can still be flushed out
    // while draining is paused.
    always_comb begin
        state_next = state;
        pop        = 1'b0;
        enter_hold = 1'b0;
        case (state)
            IDLE: begin
                if (enable && !bus.fifo_empty) begin
                    state_next = READ;
                end
            end
            READ: begin
                pop = !bus.fifo_empty && (byte_cnt < 3'd4) && enable;
                if (pop && (byte_cnt == 3'd3)) begin
                    state_next = HOLD;
                    enter_hold = 1'b1;
                end else if (!pop && flush_pending && (byte_cnt != 3'd0)) begin
                    state_next = HOLD;
                    enter_hold = 1'b1;
                end else if ((byte_cnt == 3'd0) && (!enable || bus.fifo_empty)) begin
                    state_next = IDLE;
                end
            end
            HOLD: begin
                if (bus.word_ack) begin
                    state_next = (enable && !bus.fifo_empty) ? READ : IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Byte lane for the next pop: lane k is counted from the bottom of the
    // word when LSB_FIRST is set, from the top otherwise.
    always_comb begin
        lane_sel = LSB_FIRST ? byte_cnt[1:0] : ~byte_cnt[1:0];
    end

    // Packing register. The word register is cleared when the word is
    // acknowledged so that lanes never written in the next word read as zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            word_reg <= 32'h0000_0000;
            byte_cnt <= 3'd0;
        end else begin
            if (pop) begin
                word_reg[{lane_sel, 3'b000} +: 8] <= bus.fifo_data;
                byte_cnt                          <= byte_cnt + 3'd1;
            end
            if ((state == HOLD) && bus.word_ack) begin
                word_reg <= 32'h0000_0000;
                byte_cnt <= 3'd0;
            end
        end
    end

    // A flush request is remembered until a word is closed. With nothing held
    // and nothing left in the FIFO there is no word to close, so the request
    // is dropped instead of lingering and cutting a later word short.
    always_comb begin
        flush_req     = flush | timeout_fire;
        pending_clear = (byte_cnt == 3'd0) && bus.fifo_empty;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flush_pending <= 1'b0;
        end else if (enter_hold || pending_clear) begin
            flush_pending <= 1'b0;
        end else if (flush_req) begin
            flush_pending <= 1'b1;
        end
    end

    // Threshold interrupt is a registered level that follows the occupancy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq_thresh <= 1'b0;
        end else begin
            irq_thresh <= (thresh != 9'd0) && (bus.fifo_count >= thresh);
        end
    end

`ifdef SPI_RX_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(TIMEOUT_CYCLES);

    logic [TMO_W-1:0] tmo_cnt;
    logic             tmo_counting;

    // The idle counter only runs while a partial word waits on an empty
    // FIFO. It saturates after firing so the timeout flush is a single pulse.
    always_comb begin
        tmo_counting = (state == READ) && (byte_cnt != 3'd0) && bus.fifo_empty;
        timeout_fire = tmo_counting && (tmo_cnt == TMO_LAST);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tmo_cnt      <= '0;
            timeout_flag <= 1'b0;
        end else begin
            if (!tmo_counting) begin
                tmo_cnt <= '0;
            end else if (tmo_cnt != TMO_MAX) begin
                tmo_cnt <= tmo_cnt + TMO_W'(1);
            end
            if (timeout_fire) begin
                timeout_flag <= 1'b1;
            end
        end
    end
`else
    // Without the timeout option partial words leave only through flush.
    always_comb begin
        timeout_fire = 1'b0;
        timeout_flag = 1'b0;
    end
`endif

    // Output decode. Word outputs are zero outside HOLD; in HOLD byte_cnt
    // still holds the count of bytes packed, which is exactly word_bytes.
    always_comb begin
        bus.fifo_rd_en = pop;
        bus.word_valid = (state == HOLD);
        bus.word_data  = (state == HOLD) ? word_reg : 32'h0000_0000;
        bus.word_bytes = (state == HOLD) ? byte_cnt : 3'd0;
        busy           = (state != IDLE) || (byte_cnt != 3'd0);
    end

endmodule

// File: tb/tb_spi_rx_word_packer.sv
// ---------------------------------------------------------------------------
// tb_spi_rx_word_packer
//
// Drives two packers (LSB-first and MSB-first) from one queue-based FIFO
// model and checks every emitted word against words assembled from the byte
// stream with plain shift arithmetic.
// ---------------------------------------------------------------------------
module tb_spi_rx_word_packer;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       flush;
    logic [8:0] thresh;
    logic       irq_lsb, busy_lsb, tflag_lsb;
    logic       irq_msb, busy_msb, tflag_msb;

    spi_rx_word_packer_if bus_lsb ();
    spi_rx_word_packer_if bus_msb ();

    logic [7:0] fifo_q[$];
    int checks = 0;
    int errors = 0;
    int pop_count = 0;
    int pop_empty_cnt = 0;
    int pop_while_valid_cnt = 0;
    int rd_en_diff = 0;

    always #5 clk = ~clk;

    // The MSB-first packer sees exactly the same FIFO and bus as the other.
    assign bus_msb.fifo_data  = bus_lsb.fifo_data;
    assign bus_msb.fifo_empty = bus_lsb.fifo_empty;
    assign bus_msb.fifo_count = bus_lsb.fifo_count;
    assign bus_msb.word_ack   = bus_lsb.word_ack;

    spi_rx_word_packer #(
        .LSB_FIRST(1'b1)
`ifdef SPI_RX_TIMEOUT_EN
        , .TIMEOUT_CYCLES(16)
`endif
    ) u_dut_lsb (
        .clk(clk), .reset(reset), .enable(enable), .flush(flush), .thresh(thresh),
        .bus(bus_lsb), .irq_thresh(irq_lsb), .busy(busy_lsb), .timeout_flag(tflag_lsb)
    );

    spi_rx_word_packer #(
        .LSB_FIRST(1'b0)
`ifdef SPI_RX_TIMEOUT_EN
        , .TIMEOUT_CYCLES(16)
`endif
    ) u_dut_msb (
        .clk(clk), .reset(reset), .enable(enable), .flush(flush), .thresh(thresh),
        .bus(bus_msb), .irq_thresh(irq_msb), .busy(busy_msb), .timeout_flag(tflag_msb)
    );

    // Reference packing: byte k sits at bit 8k (LSB-first) or 24-8k.
    function automatic logic [31:0] pack(input logic [7:0] b[$], input bit lsb);
        logic [31:0] w;
        w = 32'h0;
        for (int k = 0; k < b.size(); k++) begin
            if (lsb) w = w | (32'(b[k]) << (8 * k));
            else     w = w | (32'(b[k]) << (24 - 8 * k));
        end
        return w;
    endfunction

    task automatic drive_fifo();
        bus_lsb.fifo_empty = (fifo_q.size() == 0);
        bus_lsb.fifo_data  = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
        bus_lsb.fifo_count = 9'(fifo_q.size());
    endtask

    // One clock: read-enable sampled mid-cycle, FIFO model updated after edge.
    task automatic tick();
        logic pop_s;
        drive_fifo();
        @(negedge clk);
        pop_s = bus_lsb.fifo_rd_en;
        if (bus_lsb.fifo_rd_en !== bus_msb.fifo_rd_en) rd_en_diff++;
        if (pop_s === 1'b1 && bus_lsb.word_valid === 1'b1) pop_while_valid_cnt++;
        @(posedge clk);
        #1;
        if (pop_s === 1'b1) begin
            if (fifo_q.size() == 0) pop_empty_cnt++;
            else begin
                fifo_q.delete(0);
                pop_count++;
            end
        end
        drive_fifo();
    endtask

    task automatic wait_valid(input int limit, output int n);
        n = 0;
        while (bus_lsb.word_valid !== 1'b1 && n < limit) begin
            tick();
            n++;
        end
    endtask

    task automatic ack_word();
        bus_lsb.word_ack = 1'b1;
        tick();
        bus_lsb.word_ack = 1'b0;
    endtask

    task automatic pulse_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        enable = 1'b0;
        flush = 1'b0;
        thresh = 9'd0;
        bus_lsb.word_ack = 1'b0;
        fifo_q.delete();
        drive_fifo();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({bus_lsb.word_valid, bus_lsb.word_data, bus_lsb.word_bytes} !== 36'h0) begin
            errors++;
            $display("[TB] FAIL reset_word: got %0h expected 0", {bus_lsb.word_valid, bus_lsb.word_data, bus_lsb.word_bytes});
        end
        checks++;
        if ({busy_lsb, irq_lsb, tflag_lsb, bus_lsb.fifo_rd_en} !== 4'h0) begin
            errors++;
            $display("[TB] FAIL reset_status: got %0b expected 0000", {busy_lsb, irq_lsb, tflag_lsb, bus_lsb.fifo_rd_en});
        end
        @(negedge clk);
        reset = 1'b0;
        tick();
    endtask

    task automatic test_single_word();
        int n;
        int p0;
        p0 = pop_count;
        fifo_q = '{8'h11, 8'h22, 8'h33, 8'h44};
        enable = 1'b1;
        wait_valid(20, n);
        checks++;
        if (n != 5) begin
            errors++;
            $display("[TB] FAIL latency: got %0d expected 5", n);
        end
        checks++;
        if (bus_lsb.word_data !== 32'h44332211) begin
            errors++;
            $display("[TB] FAIL single_lsb_data: got %08h expected 44332211", bus_lsb.word_data);
        end
        checks++;
        if (bus_msb.word_data !== 32'h11223344) begin
            errors++;
            $display("[TB] FAIL single_msb_data: got %08h expected 11223344", bus_msb.word_data);
        end
        checks++;
        if (bus_lsb.word_bytes !== 3'd4) begin
            errors++;
            $display("[TB] FAIL single_bytes: got %0d expected 4", bus_lsb.word_bytes);
        end
        checks++;
        if (pop_count - p0 != 4) begin
            errors++;
            $display("[TB] FAIL single_pops: got %0d expected 4", pop_count - p0);
        end
        ack_word();
        checks++;
        if ({bus_lsb.word_valid, busy_lsb} !== 2'b00) begin
            errors++;
            $display("[TB] FAIL single_after_ack: got %0b expected 00", {bus_lsb.word_valid, busy_lsb});
        end
    endtask

    task automatic test_backpressure();
        int n;
        int p0;
        fifo_q = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};
        enable = 1'b1;
        wait_valid(20, n);
        p0 = pop_count;
        repeat (10) tick();
        checks++;
        if (pop_count != p0) begin
            errors++;
            $display("[TB] FAIL hold_no_pop: got %0d pops expected 0", pop_count - p0);
        end
        checks++;
        if ({bus_lsb.word_valid, bus_lsb.word_data} !== {1'b1, 32'hA3A2A1A0}) begin
            errors++;
            $display("[TB] FAIL hold_stable: got %0h expected 1a3a2a1a0", {bus_lsb.word_valid, bus_lsb.word_data});
        end
        ack_word();
        repeat (8) tick();
        checks++;
        if ({bus_lsb.word_valid, busy_lsb} !== 2'b01 || pop_count - p0 != 2) begin
            errors++;
            $display("[TB] FAIL partial_waits: got valid/busy %0b pops %0d expected 01 pops 2",
                     {bus_lsb.word_valid, busy_lsb}, pop_count - p0);
        end
        pulse_flush();
        wait_valid(10, n);
        checks++;
        if ({bus_lsb.word_data, bus_lsb.word_bytes} !== {32'h0000A5A4, 3'd2}) begin
            errors++;
            $display("[TB] FAIL flush_lsb_word: got %08h/%0d expected 0000a5a4/2", bus_lsb.word_data, bus_lsb.word_bytes);
        end
        checks++;
        if (bus_msb.word_data !== 32'hA4A50000) begin
            errors++;
            $display("[TB] FAIL flush_msb_word: got %08h expected a4a50000", bus_msb.word_data);
        end
        ack_word();
    endtask

    task automatic test_msb_first();
        int n;
        fifo_q = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        enable = 1'b1;
        wait_valid(20, n);
        checks++;
        if (bus_msb.word_data !== 32'hDEADBEEF) begin
            errors++;
            $display("[TB] FAIL msb_first: got %08h expected deadbeef", bus_msb.word_data);
        end
        checks++;
        if (bus_lsb.word_data !== 32'hEFBEADDE) begin
            errors++;
            $display("[TB] FAIL lsb_of_deadbeef: got %08h expected efbeadde", bus_lsb.word_data);
        end
        ack_word();
    endtask

    task automatic test_threshold();
        int p0;
        int th;
        int cnt;
        enable = 1'b0;
        p0 = pop_count;
        thresh = 9'd3;
        fifo_q = '{8'h01, 8'h02, 8'h03};
        drive_fifo();
        #1;
        checks++;
        if (irq_lsb !== 1'b0) begin
            errors++;
            $display("[TB] FAIL irq_registered: got %0b expected 0", irq_lsb);
        end
        tick();
        checks++;
        if (irq_lsb !== 1'b1) begin
            errors++;
            $display("[TB] FAIL irq_at_3: got %0b expected 1", irq_lsb);
        end
        fifo_q.delete(0);
        tick();
        checks++;
        if (irq_lsb !== 1'b0) begin
            errors++;
            $display("[TB] FAIL irq_at_2: got %0b expected 0", irq_lsb);
        end
        thresh = 9'd0;
        foreach (fifo_q[i]) fifo_q[i] = 8'h00;
        for (int c = 0; c < 4; c++) begin
            cnt = (c == 3) ? 511 : c * 100;
            fifo_q.delete();
            for (int i = 0; i < cnt; i++) fifo_q.push_back(8'($urandom));
            tick();
            checks++;
            if (irq_lsb !== 1'b0) begin
                errors++;
                $display("[TB] FAIL irq_disabled: got %0b expected 0 at count %0d", irq_lsb, cnt);
            end
        end
        for (int t = 0; t < 6; t++) begin
            th = $urandom_range(1, 20);
            cnt = $urandom_range(0, 25);
            thresh = 9'(th);
            fifo_q.delete();
            for (int i = 0; i < cnt; i++) fifo_q.push_back(8'($urandom));
            tick();
            checks++;
            if (irq_lsb !== 1'(cnt >= th)) begin
                errors++;
                $display("[TB] FAIL irq_random: got %0b expected %0b (count %0d thresh %0d)", irq_lsb, cnt >= th, cnt, th);
            end
        end
        checks++;
        if (pop_count != p0) begin
            errors++;
            $display("[TB] FAIL irq_no_pop_disabled: got %0d pops expected 0", pop_count - p0);
        end
        fifo_q.delete();
        thresh = 9'd0;
        tick();
    endtask

    task automatic test_reset_midword();
        int n;
        int p0;
        p0 = pop_count;
        fifo_q = '{8'h5C, 8'h3D};
        enable = 1'b1;
        n = 0;
        while (pop_count - p0 < 2 && n < 10) begin
            tick();
            n++;
        end
        checks++;
        if (busy_lsb !== 1'b1) begin
            errors++;
            $display("[TB] FAIL midword_busy: got %0b expected 1", busy_lsb);
        end
        #1 reset = 1'b1;
        #1;
        checks++;
        if ({busy_lsb, bus_lsb.word_valid, bus_lsb.word_data, bus_lsb.word_bytes, bus_lsb.fifo_rd_en} !== 38'h0) begin
            errors++;
            $display("[TB] FAIL midword_reset: got %0h expected 0",
                     {busy_lsb, bus_lsb.word_valid, bus_lsb.word_data, bus_lsb.word_bytes, bus_lsb.fifo_rd_en});
        end
        #1 reset = 1'b0;
        fifo_q = '{8'h77, 8'h88};
        p0 = pop_count;
        n = 0;
        while (pop_count - p0 < 2 && n < 10) begin
            tick();
            n++;
        end
        pulse_flush();
        wait_valid(10, n);
        checks++;
        if ({bus_lsb.word_data, bus_lsb.word_bytes} !== {32'h00008877, 3'd2}) begin
            errors++;
            $display("[TB] FAIL after_reset_word: got %08h/%0d expected 00008877/2", bus_lsb.word_data, bus_lsb.word_bytes);
        end
        ack_word();
    endtask

    task automatic test_back_to_back();
        logic [7:0] bytes[$];
        logic [7:0] grp[$];
        logic [31:0] exp_lsb[$];
        logic [31:0] exp_msb[$];
        int exp_nb[$];
        int n_bytes, pushed, cyc;
        bit flushed;
        for (int iter = 0; iter < 5; iter++) begin
            bytes.delete();
            grp.delete();
            n_bytes = $urandom_range(1, 14);
            for (int i = 0; i < n_bytes; i++) begin
                bytes.push_back(8'($urandom));
                grp.push_back(bytes[i]);
                if (grp.size() == 4 || i == n_bytes - 1) begin
                    exp_lsb.push_back(pack(grp, 1'b1));
                    exp_msb.push_back(pack(grp, 1'b0));
                    exp_nb.push_back(grp.size());
                    grp.delete();
                end
            end
            pushed = 0;
            flushed = 1'b0;
            cyc = 0;
            while (cyc < 2000 && !(flushed && exp_lsb.size() == 0 && bus_lsb.word_valid !== 1'b1)) begin
                if (pushed < n_bytes && $urandom_range(0, 1) == 1) begin
                    fifo_q.push_back(bytes[pushed]);
                    pushed++;
                end
                enable = ($urandom_range(0, 3) != 0);
                if (bus_lsb.word_valid === 1'b1 && $urandom_range(0, 2) != 0) begin
                    bus_lsb.word_ack = 1'b1;
                    checks++;
                    if (exp_lsb.size() == 0) begin
                        errors++;
                        $display("[TB] FAIL b2b_extra_word: got %08h expected no word", bus_lsb.word_data);
                    end else begin
                        if ({bus_lsb.word_data, bus_msb.word_data, bus_lsb.word_bytes} !==
                            {exp_lsb[0], exp_msb[0], 3'(exp_nb[0])}) begin
                            errors++;
                            $display("[TB] FAIL b2b_word: got %08h/%08h/%0d expected %08h/%08h/%0d",
                                     bus_lsb.word_data, bus_msb.word_data, bus_lsb.word_bytes,
                                     exp_lsb[0], exp_msb[0], exp_nb[0]);
                        end
                        exp_lsb.delete(0);
                        exp_msb.delete(0);
                        exp_nb.delete(0);
                    end
                end else if (!flushed && pushed == n_bytes && fifo_q.size() == 0 &&
                             bus_lsb.word_valid !== 1'b1) begin
                    flush = 1'b1;
                    flushed = 1'b1;
                end
                tick();
                flush = 1'b0;
                bus_lsb.word_ack = 1'b0;
                cyc++;
            end
            checks++;
            if (exp_lsb.size() != 0 || cyc >= 2000) begin
                errors++;
                $display("[TB] FAIL b2b_drain: got %0d words left after %0d cycles expected 0", exp_lsb.size(), cyc);
            end
            exp_lsb.delete();
            exp_msb.delete();
            exp_nb.delete();
            fifo_q.delete();
            enable = 1'b1;
            repeat (3) tick();
            checks++;
            if (busy_lsb !== 1'b0) begin
                errors++;
                $display("[TB] FAIL b2b_idle: got busy %0b expected 0", busy_lsb);
            end
        end
    endtask

    task automatic test_timeout();
        int n;
        int p0;
        p0 = pop_count;
        fifo_q = '{8'h5A};
        enable = 1'b1;
        n = 0;
        while (pop_count == p0 && n < 10) begin
            tick();
            n++;
        end
`ifdef SPI_RX_TIMEOUT_EN
        wait_valid(40, n);
        checks++;
        if (n < 16 || n > 20) begin
            errors++;
            $display("[TB] FAIL timeout_delay: got %0d cycles expected 16..20", n);
        end
`else
        repeat (300) tick();
        checks++;
        if ({bus_lsb.word_valid, tflag_lsb} !== 2'b00) begin
            errors++;
            $display("[TB] FAIL no_timeout: got %0b expected 00", {bus_lsb.word_valid, tflag_lsb});
        end
        pulse_flush();
        wait_valid(10, n);
`endif
        checks++;
        if ({bus_lsb.word_data, bus_lsb.word_bytes, bus_msb.word_data} !== {32'h0000005A, 3'd1, 32'h5A000000}) begin
            errors++;
            $display("[TB] FAIL single_byte_word: got %08h/%0d/%08h expected 0000005a/1/5a000000",
                     bus_lsb.word_data, bus_lsb.word_bytes, bus_msb.word_data);
        end
        ack_word();
`ifdef SPI_RX_TIMEOUT_EN
        repeat (3) tick();
        checks++;
        if (tflag_lsb !== 1'b1) begin
            errors++;
            $display("[TB] FAIL timeout_flag: got %0b expected 1", tflag_lsb);
        end
`endif
    endtask

    task automatic test_invariants();
        checks++;
        if (pop_empty_cnt != 0) begin
            errors++;
            $display("[TB] FAIL pop_empty: got %0d expected 0", pop_empty_cnt);
        end
        checks++;
        if (pop_while_valid_cnt != 0) begin
            errors++;
            $display("[TB] FAIL pop_while_valid: got %0d expected 0", pop_while_valid_cnt);
        end
        checks++;
        if (rd_en_diff != 0) begin
            errors++;
            $display("[TB] FAIL lane_order_timing: got %0d differing cycles expected 0", rd_en_diff);
        end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_backpressure();
        test_msb_first();
        test_threshold();
        test_reset_midword();
        test_back_to_back();
        test_timeout();
        test_invariants();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got no end of test expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
